audio_sample_streamer: RTL and testbench
========================================

AUDIO_SAMPLE_STREAMER -- requirements
Module: audio_sample_streamer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1200, meaning clk cycles per output sample (57.6 MHz / 48 kHz).
REQ-002 SHALL have parameter ADDR_BITS, default 24, meaning flash address width.
REQ-003 SHALL have parameter START_ADDR, default 24'h0, meaning first sample byte address.
REQ-004 SHALL have parameter NUM_SAMPLES, default 24'd480000, meaning bytes per loop (>=2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning prefetch entries (power of 2, >=2).
REQ-006 clk  input  1  sole clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  stream run request.
REQ-009 flash_addr  output  ADDR_BITS  read start address to flash controller.
REQ-010 flash_start  output  1  one-cycle pulse that begins a read at flash_addr.
REQ-011 flash_continue  output  1  one-cycle pulse that reads the next sequential byte.
REQ-012 flash_stop  output  1  one-cycle pulse that ends the current read (deselects flash).
REQ-013 flash_data  input  8  byte from controller, valid when flash_busy is low after a request.
REQ-014 flash_busy  input  1  controller transfer in progress.
REQ-015 sample  output  8  unsigned sample to the PWM stage.
REQ-016 sample_strobe  output  1  one-cycle pulse when sample updates.
REQ-017 underrun  output  1  sticky flag; FIFO empty at a sample tick while running.

Function
REQ-018 Tick counter SHALL count 0..CLK_DIV-1 while enable=1, wrapping to 0; tick = (count==CLK_DIV-1); counter held at 0 while enable=0.
REQ-019 FSM states SHALL be IDLE, START, ARM, WAIT, PUSH, NEXT, STOP.
REQ-020 IDLE->START when enable=1; START drives flash_addr=START_ADDR and pulses flash_start for exactly one cycle, then goes to ARM.
REQ-021 ARM SHALL wait for flash_busy=1, then go to WAIT; WAIT SHALL wait for flash_busy=0, then go to PUSH.
REQ-022 PUSH SHALL write flash_data into the FIFO in one cycle and increment byte_count.
REQ-023 After PUSH: if byte_count==NUM_SAMPLES, go to STOP, reset byte_count to 0 and, on leaving STOP, go to START (loop); else go to NEXT.
REQ-024 NEXT SHALL wait until the FIFO is not full, then pulse flash_continue for exactly one cycle and go to ARM.
REQ-025 STOP SHALL pulse flash_stop for exactly one cycle.
REQ-026 At most one of flash_start/flash_continue/flash_stop SHALL be high in any cycle.
REQ-027 On tick with FIFO non-empty: pop head into sample and pulse sample_strobe in the same cycle the pop occurs (registered, 1-cycle latency from tick).
REQ-028 On tick with FIFO empty: hold sample, no strobe, set underrun (cleared only by reset).
REQ-029 Simultaneous push and pop SHALL both succeed, including when the FIFO is full or empty (empty: the pop sees the old state, no bypass).
REQ-030 PUSH SHALL never occur on a full FIFO; NEXT gating guarantees this.
REQ-031 enable falling while not IDLE: if a transfer is outstanding (ARM/WAIT), finish it and discard the byte; then pulse flash_stop, flush the FIFO, set sample=8'h80, go to IDLE, reset byte_count.
REQ-032 byte_count SHALL be ADDR_BITS wide; no flash address arithmetic beyond START_ADDR is required (controller auto-increments).

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE, FIFO empty, tick counter=0, byte_count=0, sample=8'h80, sample_strobe=0, underrun=0, flash_start/continue/stop=0, flash_addr=START_ADDR.
REQ-034 Reset mid-transfer SHALL abandon it without a flash_stop pulse; the controller is reset from the same source.

Structure
REQ-035 Shared package audio_stream_pkg SHALL hold the FSM state enum and constant SILENCE=8'h80.
REQ-036 FIFO SHALL be a sub-module sample_fifo (parameterised depth/width, push/pop/full/empty, synchronous reset and flush).

Verification
REQ-037 Reset, enable=0 for 5000 cycles -> sample=8'h80, no strobes, no flash pulses, underrun=0.
REQ-038 Enable with a model returning bytes 0x01,0x02,...; busy 20 cycles -> one flash_start then flash_continue pulses; FIFO fills to 4; strobes every 1200 cycles with sample 0x01,0x02,0x03 in order.
REQ-039 NUM_SAMPLES=3, model returns 0xA0+index -> after third PUSH one flash_stop, then flash_start at START_ADDR; sample sequence A0,A1,A2,A0,A1.
REQ-040 Model busy 2000 cycles per byte -> underrun=1 at first empty tick, sample held, underrun stays 1 after recovery.
REQ-041 Deassert enable during WAIT -> transfer completes, one flash_stop, sample=8'h80, FIFO empty, state IDLE; re-enable restarts from START_ADDR.
REQ-042 Assert rst in WAIT with FIFO holding 3 entries -> all outputs at REQ-033 values the next cycle, no flash_stop pulse.

Source files
------------

// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the audio sample streamer.
// Holds the sequencer state encoding and the mid-scale silence code.
package audio_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    PUSH  = 3'd4,
    NEXT  = 3'd5,
    STOP  = 3'd6
  } stream_state_t;

  // Mid-scale code for an unsigned PWM stage (no output swing)
  localparam logic [7:0] SILENCE = 8'h80;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous prefetch FIFO with flush.
// A pop on an empty FIFO is ignored; a push on a full FIFO succeeds only when paired with a pop.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Storage is not reset; occupancy is tracked solely by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/audio_sample_streamer.sv
// Streams unsigned 8-bit samples from serial flash into a PWM stage at a fixed rate.
// A byte sequencer keeps a small FIFO topped up while a divided tick pops one sample per period.
//
// state | meaning
// IDLE  | stream stopped, waiting for enable
// START | one-cycle flash_start at START_ADDR
// ARM   | waiting for controller to go busy
// WAIT  | waiting for controller to finish the byte
// PUSH  | write returned byte into FIFO, advance byte count
// NEXT  | wait for FIFO space, then flash_continue
// STOP  | one-cycle flash_stop; loop back to START or flush to IDLE
module audio_sample_streamer
  import audio_stream_pkg::*;
#(
  parameter int                   CLK_DIV     = 1200,
  parameter int                   ADDR_BITS   = 24,
  parameter logic [ADDR_BITS-1:0] START_ADDR  = '0,
  parameter logic [ADDR_BITS-1:0] NUM_SAMPLES = ADDR_BITS'(480000),
  parameter int                   FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic [ADDR_BITS-1:0] flash_addr,
  output logic                 flash_start,
  output logic                 flash_continue,
  output logic                 flash_stop,
  input  logic [7:0]           flash_data,
  input  logic                 flash_busy,
  output logic [7:0]           sample,
  output logic                 sample_strobe,
  output logic                 underrun
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  stream_state_t        state_q, state_d;
  logic [ADDR_BITS-1:0] byte_cnt_q, byte_cnt_d;
  logic [ADDR_BITS-1:0] byte_cnt_inc;
  logic                 abort_q, abort;
  logic [CW-1:0]        div_cnt;
  logic                 tick;
  logic                 fifo_push, fifo_pop, fifo_flush;
  logic                 fifo_full, fifo_empty;
  logic [7:0]           fifo_rdata;

  // The controller auto-increments, so the start address is the only one ever issued
  assign flash_addr = START_ADDR;

  always_ff @(posedge clk) begin
    if (rst || !enable) div_cnt <= '0;
    else if (tick)      div_cnt <= '0;
    else                div_cnt <= div_cnt + CW'(1);
  end

  assign tick = enable && (div_cnt == CW'(CLK_DIV - 1));

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (flash_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign byte_cnt_inc = byte_cnt_q + ADDR_BITS'(1);
  // A stop request is remembered so an outstanding byte can finish first
  assign abort        = abort_q || !enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      abort_q    <= (state_d != IDLE) && abort;
    end
  end

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    flash_start    = 1'b0;
    flash_continue = 1'b0;
    flash_stop     = 1'b0;
    fifo_push      = 1'b0;
    fifo_flush     = 1'b0;
    case (state_q)
      IDLE: begin
        byte_cnt_d = '0;
        if (enable) state_d = START;
      end
      START: begin
        flash_start = 1'b1;
        state_d     = ARM;
      end
      ARM: begin
        if (flash_busy) state_d = WAIT;
      end
      WAIT: begin
        if (!flash_busy) state_d = abort ? STOP : PUSH;
      end
      PUSH: begin
        fifo_push = 1'b1;
        if (byte_cnt_inc == NUM_SAMPLES) begin
          byte_cnt_d = '0;
          state_d    = STOP;
        end else begin
          byte_cnt_d = byte_cnt_inc;
          state_d    = abort ? STOP : NEXT;
        end
      end
      NEXT: begin
        if (abort) begin
          state_d = STOP;
        end else if (!fifo_full) begin
          flash_continue = 1'b1;
          state_d        = ARM;
        end
      end
      STOP: begin
        flash_stop = 1'b1;
        if (abort) begin
          fifo_flush = 1'b1;
          byte_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_pop = tick && !fifo_empty && !fifo_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      sample        <= SILENCE;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (fifo_flush) begin
        sample <= SILENCE;
      end else if (fifo_pop) begin
        sample        <= fifo_rdata;
        sample_strobe <= 1'b1;
      end
      if (tick && fifo_empty) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_sample_streamer.sv
// Directed bench for audio_sample_streamer with a behavioural flash controller model.
// NUM_SAMPLES=3 so the loop/restart path is exercised alongside normal streaming.
module tb_audio_sample_streamer;
  import audio_stream_pkg::*;

  localparam int          CLK_DIV = 1200;
  localparam int          AB      = 24;
  localparam logic [23:0] SA      = 24'h123456;
  localparam logic [23:0] NS      = 24'd3;
  localparam byte         EV_S    = 8'd1;
  localparam byte         EV_C    = 8'd2;
  localparam byte         EV_P    = 8'd3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [AB-1:0] flash_addr;
  logic          flash_start, flash_continue, flash_stop;
  logic [7:0]    flash_data = 8'h00;
  logic          flash_busy = 1'b0;
  logic [7:0]    sample;
  logic          sample_strobe;
  logic          underrun;

  always #5 clk = ~clk;

  audio_sample_streamer #(
    .CLK_DIV     (CLK_DIV),
    .ADDR_BITS   (AB),
    .START_ADDR  (SA),
    .NUM_SAMPLES (NS),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .flash_addr     (flash_addr),
    .flash_start    (flash_start),
    .flash_continue (flash_continue),
    .flash_stop     (flash_stop),
    .flash_data     (flash_data),
    .flash_busy     (flash_busy),
    .sample         (sample),
    .sample_strobe  (sample_strobe),
    .underrun       (underrun)
  );

  // Flash controller model: byte n of a read is pat_base+n, busy for busy_len cycles
  int         busy_len = 20;
  logic [7:0] pat_base = 8'h00;
  logic [7:0] m_idx    = 8'h00;
  int         m_cnt    = 0;

  always @(posedge clk) begin
    if (rst) begin
      flash_busy <= 1'b0;
      m_cnt      <= 0;
      m_idx      <= 8'h00;
    end else if (flash_start || flash_continue) begin
      m_idx      <= flash_start ? 8'h00 : m_idx + 8'h01;
      flash_data <= pat_base + (flash_start ? 8'h00 : m_idx + 8'h01);
      flash_busy <= 1'b1;
      m_cnt      <= busy_len;
    end else if (flash_busy) begin
      if (m_cnt <= 1) flash_busy <= 1'b0;
      else            m_cnt <= m_cnt - 1;
    end
  end

  // Monitor
  longint     cyc = 0;
  int         n_start, n_cont, n_stop, n_strobe, n_badaddr, n_busy_rise;
  int         n_multi = 0;
  logic       busy_d = 1'b0;
  byte        ev_q[$];
  logic [7:0] smp_q[$];
  longint     t_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (flash_start) begin
      n_start++;
      ev_q.push_back(EV_S);
      if (flash_addr !== SA) n_badaddr++;
    end
    if (flash_continue) begin n_cont++; ev_q.push_back(EV_C); end
    if (flash_stop)     begin n_stop++; ev_q.push_back(EV_P); end
    if (int'(flash_start) + int'(flash_continue) + int'(flash_stop) > 1) n_multi++;
    if (sample_strobe) begin
      n_strobe++;
      smp_q.push_back(sample);
      t_q.push_back(cyc);
    end
    if (flash_busy && !busy_d) n_busy_rise++;
    busy_d = flash_busy;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    n_start = 0; n_cont = 0; n_stop = 0; n_strobe = 0;
    n_badaddr = 0; n_busy_rise = 0;
    ev_q.delete(); smp_q.delete(); t_q.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int k = 0;
    while (smp_q.size() < n && k < budget) begin step(1); k++; end
    if (smp_q.size() < n) chk({tag, "_timeout"}, smp_q.size(), n);
  endtask

  task automatic wait_busy_rise(input int n, input int budget, input string tag);
    int k = 0;
    while (n_busy_rise < n && k < budget) begin step(1); k++; end
    if (n_busy_rise < n) chk({tag, "_timeout"}, n_busy_rise, n);
  endtask

  // Start S, two continues, loop stop P, restart S
  task automatic check_ev_prefix(input string tag);
    byte exp_ev[5];
    exp_ev = '{EV_S, EV_C, EV_C, EV_P, EV_S};
    for (int i = 0; i < 5; i++)
      chk($sformatf("%s_ev%0d", tag, i), (i < ev_q.size()) ? ev_q[i] : 8'hFF, exp_ev[i]);
  endtask

  task automatic check_samples(input string tag, input logic [7:0] exp0, input logic [7:0] exp1,
                               input logic [7:0] exp2, input int n);
    logic [7:0] e [3];
    e = '{exp0, exp1, exp2};
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_smp%0d", tag, i), (i < smp_q.size()) ? smp_q[i] : 8'hXX, e[i]);
  endtask

  initial begin
    clear_logs();
    rst = 1'b1; enable = 1'b0;
    step(3);
    chk("rst_sample",   sample, SILENCE);
    chk("rst_strobe",   sample_strobe, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_addr",     flash_addr, SA);
    chk("rst_pulses",   {flash_start, flash_continue, flash_stop}, 0);
    rst = 1'b0;

    // Idle with enable low
    clear_logs();
    step(5000);
    chk("idle_strobes",  n_strobe, 0);
    chk("idle_pulses",   n_start + n_cont + n_stop, 0);
    chk("idle_sample",   sample, SILENCE);
    chk("idle_underrun", underrun, 0);

    // Normal streaming, bytes 01,02,03 then loop
    clear_logs();
    pat_base = 8'h01; busy_len = 20; enable = 1'b1;
    step(1100);
    chk("fill_ev_count", ev_q.size(), 5);
    check_ev_prefix("fill");
    chk("fill_strobes", n_strobe, 0);
    wait_strobes(3, 3000, "stream");
    check_samples("stream", 8'h01, 8'h02, 8'h03, 3);
    chk("stream_period0", 32'(t_q[1] - t_q[0]), CLK_DIV);
    chk("stream_period1", 32'(t_q[2] - t_q[1]), CLK_DIV);
    chk("stream_underrun", underrun, 0);
    enable = 1'b0;
    step(100);
    chk("stop_sample", sample, SILENCE);

    // Loop over three bytes: A0,A1,A2,A0,A1
    clear_logs();
    pat_base = 8'hA0; enable = 1'b1;
    wait_strobes(5, 7000, "loop");
    check_samples("loop", 8'hA0, 8'hA1, 8'hA2, 3);
    chk("loop_smp3", (smp_q.size() > 3) ? smp_q[3] : 8'hXX, 8'hA0);
    chk("loop_smp4", (smp_q.size() > 4) ? smp_q[4] : 8'hXX, 8'hA1);
    check_ev_prefix("loop");
    chk("loop_addr_bad", n_badaddr, 0);
    enable = 1'b0;
    step(100);

    // Deassert enable during the third transfer (FIFO holds 30,31)
    clear_logs();
    pat_base = 8'h30; enable = 1'b1;
    wait_busy_rise(3, 500, "abort");
    step(5);
    enable = 1'b0;
    step(100);
    chk("abort_stops",   n_stop, 1);
    chk("abort_starts",  n_start, 1);
    chk("abort_conts",   n_cont, 2);
    chk("abort_strobes", n_strobe, 0);
    chk("abort_sample",  sample, SILENCE);
    clear_logs();
    pat_base = 8'h50; enable = 1'b1;
    wait_strobes(2, 3000, "restart");
    check_samples("restart", 8'h50, 8'h51, 8'h00, 2);
    chk("restart_first_ev", (ev_q.size() > 0) ? ev_q[0] : 8'hFF, EV_S);
    chk("restart_addr_bad", n_badaddr, 0);
    enable = 1'b0;
    step(100);

    // Slow controller: empty at first tick
    clear_logs();
    pat_base = 8'h70; busy_len = 2000; enable = 1'b1;
    step(1250);
    chk("under_flag",    underrun, 1);
    chk("under_strobes", n_strobe, 0);
    chk("under_sample",  sample, SILENCE);
    wait_strobes(1, 1500, "recover");
    chk("recover_smp0", (smp_q.size() > 0) ? smp_q[0] : 8'hXX, 8'h70);
    step(10);
    chk("recover_flag", underrun, 1);
    enable = 1'b0;
    step(2100);
    chk("slowstop_sample", sample, SILENCE);
    chk("slowstop_flag",   underrun, 1);

    // Reset during WAIT of the fourth transfer (FIFO holds 3)
    clear_logs();
    pat_base = 8'h10; busy_len = 20; enable = 1'b1;
    wait_busy_rise(4, 500, "rstwait");
    step(5);
    rst = 1'b1;
    step(1);
    chk("rstw_sample",   sample, SILENCE);
    chk("rstw_strobe",   sample_strobe, 0);
    chk("rstw_underrun", underrun, 0);
    chk("rstw_pulses",   {flash_start, flash_continue, flash_stop}, 0);
    chk("rstw_addr",     flash_addr, SA);
    enable = 1'b0;
    step(2);
    rst = 1'b0;
    step(50);
    chk("rstw_stops", n_stop, 1);
    clear_logs();
    pat_base = 8'h60; enable = 1'b1;
    wait_strobes(1, 1500, "rstw_restart");
    chk("rstw_restart_smp0", (smp_q.size() > 0) ? smp_q[0] : 8'hXX, 8'h60);
    enable = 1'b0;
    step(100);

    chk("pulse_exclusive", n_multi, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
